alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
//  ID->EX producer for the core's ALU: decodes RV32I opcode/funct3/funct7 into the 4-bit aluctrl code.
//  Selects and forwards operands a/b/shamt, and registers them in the ID/EX pipeline register.
//  Owns the ID/EX valid bit, load-use bubble insertion, stall hold and flush. Sits between decode and ALU.
// PARAMETERS
//  XLEN  32  datapath width; must equal the global `XLEN
// PORTS
//  clk          in   1     core clock, rising edge
//  rstn         in   1     asynchronous active-low reset
//  id_valid     in   1     id_instr/id_pc/id_imm/id_rs*_data carry a real instruction
//  id_instr     in   32    raw instruction word
//  id_pc        in   XLEN  PC of id_instr
//  id_imm       in   XLEN  sign-extended immediate (decoder output)
//  id_rs1_data  in   XLEN  register-file read port 1
//  id_rs2_data  in   XLEN  register-file read port 2
//  ex_stall     in   1     downstream hold: freeze the ID/EX register
//  flush        in   1     kill the instruction entering EX (branch/jump redirect)
//  mem_rd/mem_regwrite/mem_result  in 5/1/XLEN  EX/MEM writer, forwarding source 1
//  wb_rd/wb_regwrite/wb_result     in 5/1/XLEN  MEM/WB writer, forwarding source 2
//  id_stall     out  1     comb: ID must hold its instruction this cycle
//  ex_valid     out  1     ID/EX holds a live instruction
//  ex_a, ex_b   out  XLEN  ALU operands
//  ex_shamt     out  5     ALU shift amount
//  ex_aluctrl   out  4     ALU_CTRL_* code
//  ex_rd        out  5     destination register
//  ex_regwrite  out  1     instruction writes rd (forced 0 when rd==0)
//  ex_memread   out  1     instruction is a load
// BEHAVIOUR
//  - Reset (rstn=0, async): every ex_* register is 0. id_stall follows its equation (0 in reset, since ex_valid=0).
//  - hazard = ex_valid & ex_memread & ex_rd!=0 & ((ex_rd==rs1 & rs1 used) | (ex_rd==rs2 & rs2 used)).
//  - id_stall = ex_stall | hazard.
//  - Each edge, priority order:
//    - flush: ex_valid, ex_regwrite and ex_memread go to 0.
//    - ex_stall: every ex_* register holds.
//    - hazard: insert a bubble (ex_valid, ex_regwrite and ex_memread go to 0).
//    - otherwise: load the decoded id_* into ex_*; ex_valid becomes id_valid.
//  - Latency: one cycle, ID to ex_*. One instruction per cycle with no hazard.
//  - Decode table:
//    - OP/OP-IMM: ADD, SUB (OP only, funct7[5]=1), SLL, SLT, SLTU, XOR, SRL, SRA (funct7[5]=1), OR, AND.
//    - OP-IMM: b=id_imm. OP: b=rs2.
//    - LUI: a=0, b=imm, ALU_CTRL_LUI. AUIPC: a=pc, b=imm, ALU_CTRL_AUIPC.
//    - LOAD/STORE: ALU_CTRL_ADD, a=rs1, b=imm. ex_memread=1 for LOAD.
//    - BRANCH: a=rs1, b=rs2. beq/bne->ALU_CTRL_ZERO, blt/bge->ALU_CTRL_ADDU, bltu/bgeu->ALU_CTRL_SUBU. regwrite=0.
//    - JAL/JALR: ALU_CTRL_ADD, a=pc, b=4 (link value).
//    - Any other opcode: ALU_CTRL_MOVEA, regwrite=0, memread=0. ex_valid still passes.
//  - ex_shamt: imm[4:0] for OP-IMM shifts; rs2-operand[4:0] for OP shifts; 0 otherwise.
//  - "rs used": OP, BRANCH and STORE use rs1 and rs2. OP-IMM, LOAD and JALR use rs1 only. Others use neither.
//  - x0 is never forwarded and never creates a hazard.
// CONFIGURATION
//  - ALU_ISSUE_FWD_EN defined:
//    - rs operands come from mem_result when mem_regwrite & mem_rd==rs & rs!=0.
//    - Else from wb_result under the same rule for wb_*. Else from id_rs*_data. MEM beats WB.
//    - Stalls come only from the load-use hazard.
//  - ALU_ISSUE_FWD_EN undefined:
//    - No forwarding mux; operands are id_rs*_data.
//    - hazard is additionally raised when a used rs!=0 matches an active writer in EX (ex_valid & ex_regwrite & ex_rd), MEM (mem_regwrite & mem_rd) or WB (wb_regwrite & wb_rd).
// STRUCTURE
//  - Shared defines header: ALU_CTRL_* codes, RV32I opcode constants (OP, OP_IMM, LUI, AUIPC, LOAD, STORE, BRANCH, JAL, JALR), funct3 constants, `XLEN.
//  - One sub-module: alu_ctrl_decode (comb; instr -> aluctrl, a/b select, shamt select, rs-used flags, regwrite, memread).
//  - Top level: forwarding/hazard logic plus the ID/EX register.
// TESTING
//  - Reset: rstn=0 mid-stream -> all ex_* 0 immediately. First edge after release with id_valid=1 issues normally.
//  - add x3,x1,x2 with rs1=5, rs2=7 -> next cycle ex_aluctrl=ALU_CTRL_ADD, ex_a=5, ex_b=7, ex_rd=3, ex_regwrite=1.
//  - srai x5,x6,3 with x6=0x80000000 -> ex_aluctrl=ALU_CTRL_SRA, ex_shamt=3, ex_b=imm.
//  - lw x4,0(x1), then add x5,x4,x4 -> id_stall=1 for one cycle, one bubble (ex_valid=0), then add issues.
//    - With ALU_ISSUE_FWD_EN: operands taken from wb_result on the following cycle.
//  - FWD_EN: mem_rd=wb_rd=2, mem_result=0x11, wb_result=0x22, rs2=x2 -> ex_b=0x11. mem_rd=0 case -> uses id_rs2_data.
//  - flush and ex_stall asserted together with a valid bltu in ID -> ex_valid=0 next cycle.
//    - ex_stall alone for 3 cycles -> ex_* unchanged, id_stall=1 throughout.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared constants for the ALU issue stage: ALU control codes, RV32I opcode/funct3
// values, decoder output struct and the global XLEN default.
`ifndef XLEN
`define XLEN 32
`endif

package alu_issue_pkg;

    localparam logic [3:0] ALU_CTRL_ADD   = 4'd0;
    localparam logic [3:0] ALU_CTRL_SUB   = 4'd1;
    localparam logic [3:0] ALU_CTRL_SLL   = 4'd2;
    localparam logic [3:0] ALU_CTRL_SLT   = 4'd3;
    localparam logic [3:0] ALU_CTRL_SLTU  = 4'd4;
    localparam logic [3:0] ALU_CTRL_XOR   = 4'd5;
    localparam logic [3:0] ALU_CTRL_SRL   = 4'd6;
    localparam logic [3:0] ALU_CTRL_SRA   = 4'd7;
    localparam logic [3:0] ALU_CTRL_OR    = 4'd8;
    localparam logic [3:0] ALU_CTRL_AND   = 4'd9;
    localparam logic [3:0] ALU_CTRL_LUI   = 4'd10;
    localparam logic [3:0] ALU_CTRL_AUIPC = 4'd11;
    localparam logic [3:0] ALU_CTRL_ZERO  = 4'd12;
    localparam logic [3:0] ALU_CTRL_ADDU  = 4'd13;
    localparam logic [3:0] ALU_CTRL_SUBU  = 4'd14;
    localparam logic [3:0] ALU_CTRL_MOVEA = 4'd15;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {ASEL_RS1, ASEL_PC, ASEL_ZERO} asel_e;
    typedef enum logic [1:0] {BSEL_RS2, BSEL_IMM, BSEL_FOUR} bsel_e;
    typedef enum logic [1:0] {SHSEL_ZERO, SHSEL_IMM, SHSEL_RS2} shsel_e;

    typedef struct packed {
        logic [3:0] aluctrl;
        asel_e      asel;
        bsel_e      bsel;
        shsel_e     shsel;
        logic       rs1_used;
        logic       rs2_used;
        logic       regwrite;
        logic       memread;
    } dec_t;

    // SUB only exists in the register form; the I-form bit 30 is immediate data.
    function automatic logic [3:0] arith_ctrl(input logic [2:0] f3, input logic alt,
                                              input logic is_op);
        logic [3:0] c;
        case (f3)
            F3_ADD_SUB: c = (is_op && alt) ? ALU_CTRL_SUB : ALU_CTRL_ADD;
            F3_SLL:     c = ALU_CTRL_SLL;
            F3_SLT:     c = ALU_CTRL_SLT;
            F3_SLTU:    c = ALU_CTRL_SLTU;
            F3_XOR:     c = ALU_CTRL_XOR;
            F3_SRL_SRA: c = alt ? ALU_CTRL_SRA : ALU_CTRL_SRL;
            F3_OR:      c = ALU_CTRL_OR;
            default:    c = ALU_CTRL_AND;
        endcase
        return c;
    endfunction

    function automatic logic is_shift(input logic [2:0] f3);
        return (f3 == F3_SLL) || (f3 == F3_SRL_SRA);
    endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational RV32I decode: instruction word -> ALU control code, operand/shamt
// selects, register-use flags, regwrite and memread.
module alu_ctrl_decode
    import alu_issue_pkg::*;
(
    input  logic [31:0] instr_i,
    output dec_t        dec_o
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic       alt;
    logic       unused_instr;

    assign opc          = instr_i[6:0];
    assign f3           = instr_i[14:12];
    assign alt          = instr_i[30];
    assign unused_instr = ^{instr_i[31], instr_i[29:15], instr_i[11:7]};

    always_comb begin
        dec_o         = '0;
        dec_o.aluctrl = ALU_CTRL_MOVEA;
        case (opc)
            OPC_OP: begin
                dec_o.aluctrl  = arith_ctrl(f3, alt, 1'b1);
                dec_o.shsel    = is_shift(f3) ? SHSEL_RS2 : SHSEL_ZERO;
                dec_o.rs1_used = 1'b1;
                dec_o.rs2_used = 1'b1;
                dec_o.regwrite = 1'b1;
            end
            OPC_OP_IMM: begin
                dec_o.aluctrl  = arith_ctrl(f3, alt, 1'b0);
                dec_o.bsel     = BSEL_IMM;
                dec_o.shsel    = is_shift(f3) ? SHSEL_IMM : SHSEL_ZERO;
                dec_o.rs1_used = 1'b1;
                dec_o.regwrite = 1'b1;
            end
            OPC_LUI: begin
                dec_o.aluctrl  = ALU_CTRL_LUI;
                dec_o.asel     = ASEL_ZERO;
                dec_o.bsel     = BSEL_IMM;
                dec_o.regwrite = 1'b1;
            end
            OPC_AUIPC: begin
                dec_o.aluctrl  = ALU_CTRL_AUIPC;
                dec_o.asel     = ASEL_PC;
                dec_o.bsel     = BSEL_IMM;
                dec_o.regwrite = 1'b1;
            end
            OPC_LOAD: begin
                dec_o.aluctrl  = ALU_CTRL_ADD;
                dec_o.bsel     = BSEL_IMM;
                dec_o.rs1_used = 1'b1;
                dec_o.regwrite = 1'b1;
                dec_o.memread  = 1'b1;
            end
            OPC_STORE: begin
                dec_o.aluctrl  = ALU_CTRL_ADD;
                dec_o.bsel     = BSEL_IMM;
                dec_o.rs1_used = 1'b1;
                dec_o.rs2_used = 1'b1;
            end
            OPC_BRANCH: begin
                case (f3)
                    F3_BEQ, F3_BNE:   dec_o.aluctrl = ALU_CTRL_ZERO;
                    F3_BLT, F3_BGE:   dec_o.aluctrl = ALU_CTRL_ADDU;
                    F3_BLTU, F3_BGEU: dec_o.aluctrl = ALU_CTRL_SUBU;
                    default:          dec_o.aluctrl = ALU_CTRL_MOVEA;
                endcase
                dec_o.rs1_used = 1'b1;
                dec_o.rs2_used = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                // ALU produces the link value pc+4; the target is computed elsewhere.
                dec_o.aluctrl  = ALU_CTRL_ADD;
                dec_o.asel     = ASEL_PC;
                dec_o.bsel     = BSEL_FOUR;
                dec_o.rs1_used = (opc == OPC_JALR);
                dec_o.regwrite = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID->EX issue stage: operand select/forwarding, hazard detection and the ID/EX
// register. Define ALU_ISSUE_FWD_EN to enable MEM/WB operand forwarding.
module alu_issue_stage
    import alu_issue_pkg::*;
#(
    parameter int XLEN = `XLEN
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            id_valid,
    input  logic [31:0]     id_instr,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_imm,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic            ex_stall,
    input  logic            flush,
    input  logic [4:0]      mem_rd,
    input  logic            mem_regwrite,
    input  logic [XLEN-1:0] mem_result,
    input  logic [4:0]      wb_rd,
    input  logic            wb_regwrite,
    input  logic [XLEN-1:0] wb_result,
    output logic            id_stall,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_a,
    output logic [XLEN-1:0] ex_b,
    output logic [4:0]      ex_shamt,
    output logic [3:0]      ex_aluctrl,
    output logic [4:0]      ex_rd,
    output logic            ex_regwrite,
    output logic            ex_memread
);

    dec_t            dec;
    logic [4:0]      rs1, rs2, rd;
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic            load_use, dep_hazard, hazard;

    logic            ex_valid_q, ex_regwrite_q, ex_memread_q;
    logic [XLEN-1:0] ex_a_q, ex_b_q, ex_a_d, ex_b_d;
    logic [4:0]      ex_shamt_q, ex_shamt_d, ex_rd_q;
    logic [3:0]      ex_aluctrl_q;
    logic            ex_regwrite_d;

    assign rs1 = id_instr[19:15];
    assign rs2 = id_instr[24:20];
    assign rd  = id_instr[11:7];

    alu_ctrl_decode u_dec (
        .instr_i (id_instr),
        .dec_o   (dec)
    );

`ifdef ALU_ISSUE_FWD_EN
    // MEM is the younger writer, so it wins over WB.
    always_comb begin
        rs1_val = id_rs1_data;
        if (mem_regwrite && mem_rd == rs1 && rs1 != 5'd0)
            rs1_val = mem_result;
        else if (wb_regwrite && wb_rd == rs1 && rs1 != 5'd0)
            rs1_val = wb_result;
    end

    always_comb begin
        rs2_val = id_rs2_data;
        if (mem_regwrite && mem_rd == rs2 && rs2 != 5'd0)
            rs2_val = mem_result;
        else if (wb_regwrite && wb_rd == rs2 && rs2 != 5'd0)
            rs2_val = wb_result;
    end

    assign dep_hazard = 1'b0;
`else
    logic rs1_busy, rs2_busy;
    logic unused_results;

    assign rs1_val        = id_rs1_data;
    assign rs2_val        = id_rs2_data;
    assign unused_results = ^{mem_result, wb_result};

    // Without forwarding any in-flight writer of a source register must drain first.
    assign rs1_busy = (rs1 != 5'd0) &&
                      ((ex_valid_q && ex_regwrite_q && ex_rd_q == rs1) ||
                       (mem_regwrite && mem_rd == rs1) ||
                       (wb_regwrite && wb_rd == rs1));
    assign rs2_busy = (rs2 != 5'd0) &&
                      ((ex_valid_q && ex_regwrite_q && ex_rd_q == rs2) ||
                       (mem_regwrite && mem_rd == rs2) ||
                       (wb_regwrite && wb_rd == rs2));

    assign dep_hazard = (dec.rs1_used && rs1_busy) || (dec.rs2_used && rs2_busy);
`endif

    assign load_use = ex_valid_q && ex_memread_q && (ex_rd_q != 5'd0) &&
                      ((ex_rd_q == rs1 && dec.rs1_used) || (ex_rd_q == rs2 && dec.rs2_used));
    assign hazard   = load_use || dep_hazard;
    assign id_stall = ex_stall || hazard;

    always_comb begin
        case (dec.asel)
            ASEL_PC:   ex_a_d = id_pc;
            ASEL_ZERO: ex_a_d = '0;
            default:   ex_a_d = rs1_val;
        endcase
        case (dec.bsel)
            BSEL_IMM:  ex_b_d = id_imm;
            BSEL_FOUR: ex_b_d = XLEN'(4);
            default:   ex_b_d = rs2_val;
        endcase
        case (dec.shsel)
            SHSEL_IMM: ex_shamt_d = id_imm[4:0];
            SHSEL_RS2: ex_shamt_d = rs2_val[4:0];
            default:   ex_shamt_d = 5'd0;
        endcase
        ex_regwrite_d = dec.regwrite && (rd != 5'd0);
    end

    // Priority: flush, then stall hold, then bubble, then normal issue.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ex_valid_q    <= 1'b0;
            ex_a_q        <= '0;
            ex_b_q        <= '0;
            ex_shamt_q    <= '0;
            ex_aluctrl_q  <= '0;
            ex_rd_q       <= '0;
            ex_regwrite_q <= 1'b0;
            ex_memread_q  <= 1'b0;
        end else if (flush) begin
            ex_valid_q    <= 1'b0;
            ex_regwrite_q <= 1'b0;
            ex_memread_q  <= 1'b0;
        end else if (ex_stall) begin
            ex_valid_q    <= ex_valid_q;
        end else if (hazard) begin
            ex_valid_q    <= 1'b0;
            ex_regwrite_q <= 1'b0;
            ex_memread_q  <= 1'b0;
        end else begin
            ex_valid_q    <= id_valid;
            ex_a_q        <= ex_a_d;
            ex_b_q        <= ex_b_d;
            ex_shamt_q    <= ex_shamt_d;
            ex_aluctrl_q  <= dec.aluctrl;
            ex_rd_q       <= rd;
            ex_regwrite_q <= ex_regwrite_d;
            ex_memread_q  <= dec.memread;
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_a        = ex_a_q;
    assign ex_b        = ex_b_q;
    assign ex_shamt    = ex_shamt_q;
    assign ex_aluctrl  = ex_aluctrl_q;
    assign ex_rd       = ex_rd_q;
    assign ex_regwrite = ex_regwrite_q;
    assign ex_memread  = ex_memread_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode table, hazards, flush/stall and reset.
`timescale 1ns/1ps
module tb_alu_issue_stage;
    import alu_issue_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        id_valid = 1'b0;
    logic [31:0] id_instr = '0, id_pc = '0, id_imm = '0, id_rs1_data = '0, id_rs2_data = '0;
    logic        ex_stall = 1'b0, flush = 1'b0;
    logic [4:0]  mem_rd = '0, wb_rd = '0;
    logic        mem_regwrite = 1'b0, wb_regwrite = 1'b0;
    logic [31:0] mem_result = '0, wb_result = '0;
    logic        id_stall, ex_valid, ex_regwrite, ex_memread;
    logic [31:0] ex_a, ex_b;
    logic [4:0]  ex_shamt, ex_rd;
    logic [3:0]  ex_aluctrl;

    int n_chk = 0;
    int n_err = 0;

    alu_issue_stage #(.XLEN(32)) dut (
        .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
        .id_imm(id_imm), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .ex_stall(ex_stall), .flush(flush),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_result(mem_result),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .wb_result(wb_result),
        .id_stall(id_stall), .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b),
        .ex_shamt(ex_shamt), .ex_aluctrl(ex_aluctrl), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic chk_ex(input string tag, input logic v, input logic [3:0] c,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                          input logic [4:0] rd, input logic rw, input logic mr);
        chk({tag, ".valid"}, 32'(ex_valid), 32'(v));
        chk({tag, ".ctrl"},  32'(ex_aluctrl), 32'(c));
        chk({tag, ".a"},     ex_a, a);
        chk({tag, ".b"},     ex_b, b);
        chk({tag, ".shamt"}, 32'(ex_shamt), 32'(sh));
        chk({tag, ".rd"},    32'(ex_rd), 32'(rd));
        chk({tag, ".rw"},    32'(ex_regwrite), 32'(rw));
        chk({tag, ".mr"},    32'(ex_memread), 32'(mr));
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] r1, input logic [31:0] r2);
        id_valid    = 1'b1;
        id_instr    = ins;
        id_pc       = pc;
        id_imm      = imm;
        id_rs1_data = r1;
        id_rs2_data = r2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rstn = 1'b0;
        #1;
        chk_ex("reset", 1'b0, 4'd0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0);
        chk("reset.id_stall", 32'(id_stall), 32'd0);

        // add x3,x1,x2 issued on the first edge after release
        drive(enc_r(7'h00, 5'd2, 5'd1, F3_ADD_SUB, 5'd3, OPC_OP), 32'h0, 32'h0, 32'd5, 32'd7);
        @(negedge clk) rstn = 1'b1;
        tick();
        chk_ex("add", 1'b1, ALU_CTRL_ADD, 32'd5, 32'd7, 5'd0, 5'd3, 1'b1, 1'b0);

        drive(enc_i(12'h403, 5'd6, F3_SRL_SRA, 5'd5, OPC_OP_IMM), 32'h0, 32'h403, 32'h8000_0000, 32'h0);
        tick();
        chk_ex("srai", 1'b1, ALU_CTRL_SRA, 32'h8000_0000, 32'h403, 5'd3, 5'd5, 1'b1, 1'b0);

        drive(enc_r(7'h20, 5'd2, 5'd1, F3_ADD_SUB, 5'd7, OPC_OP), 32'h0, 32'h0, 32'd10, 32'd3);
        tick();
        chk_ex("sub", 1'b1, ALU_CTRL_SUB, 32'd10, 32'd3, 5'd0, 5'd7, 1'b1, 1'b0);

        drive(enc_r(7'h00, 5'd2, 5'd1, F3_SLL, 5'd8, OPC_OP), 32'h0, 32'h0, 32'h1, 32'h25);
        tick();
        chk_ex("sll", 1'b1, ALU_CTRL_SLL, 32'h1, 32'h25, 5'd5, 5'd8, 1'b1, 1'b0);

        drive({20'h12345, 5'd9, OPC_LUI}, 32'h0, 32'h1234_5000, 32'hDEAD, 32'hBEEF);
        tick();
        chk_ex("lui", 1'b1, ALU_CTRL_LUI, 32'h0, 32'h1234_5000, 5'd0, 5'd9, 1'b1, 1'b0);

        drive({20'h00002, 5'd10, OPC_AUIPC}, 32'h100, 32'h2000, 32'hDEAD, 32'hBEEF);
        tick();
        chk_ex("auipc", 1'b1, ALU_CTRL_AUIPC, 32'h100, 32'h2000, 5'd0, 5'd10, 1'b1, 1'b0);

        drive({20'h00010, 5'd11, OPC_JAL}, 32'h200, 32'h10, 32'hDEAD, 32'hBEEF);
        tick();
        chk_ex("jal", 1'b1, ALU_CTRL_ADD, 32'h200, 32'h4, 5'd0, 5'd11, 1'b1, 1'b0);

        drive(enc_r(7'h00, 5'd2, 5'd1, F3_BLTU, 5'd0, OPC_BRANCH), 32'h0, 32'h0, 32'd3, 32'd9);
        tick();
        chk_ex("bltu", 1'b1, ALU_CTRL_SUBU, 32'd3, 32'd9, 5'd0, 5'd0, 1'b0, 1'b0);

        drive(enc_r(7'h00, 5'd2, 5'd1, F3_BEQ, 5'd0, OPC_BRANCH), 32'h0, 32'h0, 32'd4, 32'd4);
        tick();
        chk("beq.ctrl", 32'(ex_aluctrl), 32'(ALU_CTRL_ZERO));

        drive(enc_r(7'h00, 5'd2, 5'd1, F3_BLT, 5'd0, OPC_BRANCH), 32'h0, 32'h0, 32'd4, 32'd4);
        tick();
        chk("blt.ctrl", 32'(ex_aluctrl), 32'(ALU_CTRL_ADDU));

        drive({7'h00, 5'd2, 5'd1, 3'b010, 5'd8, OPC_STORE}, 32'h0, 32'h8, 32'h1000, 32'h77);
        tick();
        chk_ex("sw", 1'b1, ALU_CTRL_ADD, 32'h1000, 32'h8, 5'd0, 5'd8, 1'b0, 1'b0);

        drive(enc_i(12'h000, 5'd0, 3'b000, 5'd1, 7'b1110011), 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        chk("other.valid", 32'(ex_valid), 32'd1);
        chk("other.ctrl", 32'(ex_aluctrl), 32'(ALU_CTRL_MOVEA));
        chk("other.rw", 32'(ex_regwrite), 32'd0);

        drive(enc_r(7'h00, 5'd2, 5'd1, F3_ADD_SUB, 5'd0, OPC_OP), 32'h0, 32'h0, 32'd1, 32'd1);
        tick();
        chk("add_x0.rw", 32'(ex_regwrite), 32'd0);

        // load-use: lw x4,0(x1) then add x5,x4,x4
        drive(enc_i(12'h000, 5'd1, 3'b010, 5'd4, OPC_LOAD), 32'h0, 32'h0, 32'h2000, 32'h0);
        #1 chk("lw.id_stall", 32'(id_stall), 32'd0);
        tick();
        chk_ex("lw", 1'b1, ALU_CTRL_ADD, 32'h2000, 32'h0, 5'd0, 5'd4, 1'b1, 1'b1);
        drive(enc_r(7'h00, 5'd4, 5'd4, F3_ADD_SUB, 5'd5, OPC_OP), 32'h0, 32'h0, 32'h33, 32'h33);
        #1 chk("lu.id_stall", 32'(id_stall), 32'd1);
        tick();
        chk("bubble.valid", 32'(ex_valid), 32'd0);
        chk("bubble.rw", 32'(ex_regwrite), 32'd0);
        chk("bubble.mr", 32'(ex_memread), 32'd0);
`ifdef ALU_ISSUE_FWD_EN
        wb_rd = 5'd4; wb_regwrite = 1'b1; wb_result = 32'h99;
        #1 chk("lu2.id_stall", 32'(id_stall), 32'd0);
        tick();
        chk_ex("lu_add", 1'b1, ALU_CTRL_ADD, 32'h99, 32'h99, 5'd0, 5'd5, 1'b1, 1'b0);
        wb_regwrite = 1'b0;

        drive(enc_r(7'h00, 5'd2, 5'd1, F3_ADD_SUB, 5'd3, OPC_OP), 32'h0, 32'h0, 32'h55, 32'd7);
        mem_rd = 5'd2; mem_regwrite = 1'b1; mem_result = 32'h11;
        wb_rd = 5'd2;  wb_regwrite = 1'b1;  wb_result = 32'h22;
        #1 chk("fwd.id_stall", 32'(id_stall), 32'd0);
        tick();
        chk("fwd_mem.a", ex_a, 32'h55);
        chk("fwd_mem.b", ex_b, 32'h11);
        mem_rd = 5'd0; wb_regwrite = 1'b0;
        tick();
        chk("fwd_none.b", ex_b, 32'd7);
        mem_regwrite = 1'b0; wb_regwrite = 1'b1;
        tick();
        chk("fwd_wb.b", ex_b, 32'h22);
        wb_regwrite = 1'b0;
        drive(enc_r(7'h00, 5'd0, 5'd3, F3_ADD_SUB, 5'd6, OPC_OP), 32'h0, 32'h0, 32'h1, 32'h0);
        #1 chk("fwd_ex_dep.id_stall", 32'(id_stall), 32'd0);
`else
        #1 chk("lu2.id_stall", 32'(id_stall), 32'd0);
        tick();
        chk_ex("lu_add", 1'b1, ALU_CTRL_ADD, 32'h33, 32'h33, 5'd0, 5'd5, 1'b1, 1'b0);

        drive(enc_r(7'h00, 5'd2, 5'd1, F3_ADD_SUB, 5'd3, OPC_OP), 32'h0, 32'h0, 32'h55, 32'd7);
        mem_rd = 5'd2; mem_regwrite = 1'b1;
        #1 chk("dep_mem.id_stall", 32'(id_stall), 32'd1);
        drive(enc_r(7'h00, 5'd0, 5'd0, F3_ADD_SUB, 5'd3, OPC_OP), 32'h0, 32'h0, 32'h0, 32'h0);
        mem_rd = 5'd0;
        #1 chk("dep_x0.id_stall", 32'(id_stall), 32'd0);
        mem_regwrite = 1'b0; wb_rd = 5'd1; wb_regwrite = 1'b1;
        drive(enc_r(7'h00, 5'd2, 5'd1, F3_ADD_SUB, 5'd3, OPC_OP), 32'h0, 32'h0, 32'h55, 32'd7);
        #1 chk("dep_wb.id_stall", 32'(id_stall), 32'd1);
        wb_regwrite = 1'b0;
        drive(enc_r(7'h00, 5'd0, 5'd5, F3_ADD_SUB, 5'd6, OPC_OP), 32'h0, 32'h0, 32'h1, 32'h0);
        #1 chk("dep_ex.id_stall", 32'(id_stall), 32'd1);
        drive({20'h00001, 5'd5, OPC_LUI}, 32'h0, 32'h1000, 32'h0, 32'h0);
        #1 chk("dep_none.id_stall", 32'(id_stall), 32'd0);
`endif

        // flush + stall together on a valid bltu
        drive(enc_r(7'h00, 5'd2, 5'd1, F3_BLTU, 5'd0, OPC_BRANCH), 32'h0, 32'h0, 32'd3, 32'd9);
        flush = 1'b1; ex_stall = 1'b1;
        tick();
        chk("flush.valid", 32'(ex_valid), 32'd0);
        chk("flush.rw", 32'(ex_regwrite), 32'd0);
        flush = 1'b0; ex_stall = 1'b0;

        drive(enc_r(7'h00, 5'd14, 5'd13, F3_XOR, 5'd12, OPC_OP), 32'h0, 32'h0, 32'hF0, 32'h0F);
        tick();
        chk_ex("xor", 1'b1, ALU_CTRL_XOR, 32'hF0, 32'h0F, 5'd0, 5'd12, 1'b1, 1'b0);
        ex_stall = 1'b1;
        drive({20'hABCDE, 5'd15, OPC_LUI}, 32'h0, 32'hABCD_E000, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall.id_stall", 32'(id_stall), 32'd1);
            tick();
            chk_ex("stall_hold", 1'b1, ALU_CTRL_XOR, 32'hF0, 32'h0F, 5'd0, 5'd12, 1'b1, 1'b0);
        end
        ex_stall = 1'b0;

        // asynchronous reset mid-cycle, then issue on the first edge after release
        #2 rstn = 1'b0;
        #1;
        chk_ex("reset2", 1'b0, 4'd0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0);
        chk("reset2.id_stall", 32'(id_stall), 32'd0);
        drive(enc_r(7'h00, 5'd2, 5'd1, F3_OR, 5'd3, OPC_OP), 32'h0, 32'h0, 32'h5, 32'hA);
        @(negedge clk) rstn = 1'b1;
        tick();
        chk_ex("post_reset", 1'b1, ALU_CTRL_OR, 32'h5, 32'hA, 5'd0, 5'd3, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
